// File: rtl/eeprom_ctrl.sv
// rtl/eeprom_ctrl.sv - AT28C64-style parallel EEPROM pin sequencer for a single-beat master
// Define EEPROM_DATA_POLL_EN to finish writes by DATA# polling instead of a fixed tWC wait.
module eeprom_ctrl #(
    parameter int ADDR_W       = 13,
    parameter int RD_CYCLES    = 3,
    parameter int WE_CYCLES    = 4,
    parameter int WRITE_CYCLES = 20000,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ee_a,
    output logic              ee_ce_n,
    output logic              ee_oe_n,
    output logic              ee_we_n,
    output logic [7:0]        ee_d_o,
    output logic              ee_d_oe,
    input  logic [7:0]        ee_d_i
);

`ifdef EEPROM_DATA_POLL_EN
    typedef enum logic [3:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, POLL_GAP, POLL_RD, RESP} state_t;
`else
    typedef enum logic [3:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, WR_WAIT, RESP} state_t;
`endif

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WT_LAST = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WT_MAX  = CNT_W'(WRITE_CYCLES);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  ph_cnt;
    logic [CNT_W-1:0]  wt_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        rdata_q;
    logic              err_q;
    logic              err_d;
    logic              in_wait;
    logic              timeout;

    assign timeout = (wt_cnt >= WT_LAST);

`ifdef EEPROM_DATA_POLL_EN
    logic poll_done;
    // DATA# polling: bit 7 reads back inverted until the internal write finishes
    assign poll_done = (ee_d_i[7] == wdata_q[7]);
    assign in_wait   = (state_q == POLL_GAP) || (state_q == POLL_RD);
`else
    assign in_wait   = (state_q == WR_WAIT);
`endif

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE:     if (req_valid) state_d = req_we ? WR_SETUP : RD;
            RD:       if (ph_cnt == RD_LAST) state_d = RESP;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: if (ph_cnt == WE_LAST) state_d = WR_HOLD;
`ifdef EEPROM_DATA_POLL_EN
            WR_HOLD:  state_d = POLL_GAP;
            POLL_GAP: begin
                if (timeout) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    state_d = POLL_RD;
                end
            end
            POLL_RD: begin
                if (ph_cnt == RD_LAST && poll_done) begin
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (ph_cnt == RD_LAST) begin
                    state_d = POLL_GAP;
                end
            end
`else
            WR_HOLD:  state_d = WR_WAIT;
            WR_WAIT:  if (timeout) state_d = RESP;
`endif
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Pins decode straight from the state register so an async reset releases them at once
    always_comb begin
        ee_ce_n = 1'b1;
        ee_oe_n = 1'b1;
        ee_we_n = 1'b1;
        ee_d_oe = 1'b0;
        case (state_q)
            RD: begin
                ee_ce_n = 1'b0;
                ee_oe_n = 1'b0;
            end
`ifdef EEPROM_DATA_POLL_EN
            POLL_RD: begin
                ee_ce_n = 1'b0;
                ee_oe_n = 1'b0;
            end
`endif
            WR_SETUP, WR_HOLD: begin
                ee_ce_n = 1'b0;
                ee_d_oe = 1'b1;
            end
            WR_PULSE: begin
                ee_ce_n = 1'b0;
                ee_we_n = 1'b0;
                ee_d_oe = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ph_cnt  <= '0;
            wt_cnt  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_d != state_q) ph_cnt <= '0;
            else                    ph_cnt <= ph_cnt + CNT_W'(1);
            if (state_q == WR_HOLD)                wt_cnt <= '0;
            else if (in_wait && wt_cnt != WT_MAX)  wt_cnt <= wt_cnt + CNT_W'(1);
            if (state_q == RD && state_d == RESP) rdata_q <= ee_d_i;
`ifdef EEPROM_DATA_POLL_EN
            if (state_q == POLL_RD && state_d == RESP && !err_d) rdata_q <= ee_d_i;
`endif
            if (state_d == RESP && state_q != RESP) err_q <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign ee_a      = addr_q;
    assign ee_d_o    = wdata_q;

endmodule

// File: tb/tb_eeprom_ctrl.sv
// tb/tb_eeprom_ctrl.sv - directed vector bench for eeprom_ctrl with a behavioural AT28C64 model
module tb_eeprom_ctrl;
    localparam int AW   = 13;
    localparam int RDC  = 3;
    localparam int WEC  = 4;
    localparam int WC   = 50;
    localparam int MAXW = 300;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [7:0]    req_wdata = '0;
    logic          rsp_valid;
    logic [7:0]    rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] ee_a;
    logic          ee_ce_n, ee_oe_n, ee_we_n, ee_d_oe;
    logic [7:0]    ee_d_o, ee_d_i;

    int checks = 0;
    int errors = 0;

    eeprom_ctrl #(.ADDR_W(AW), .RD_CYCLES(RDC), .WE_CYCLES(WEC), .WRITE_CYCLES(WC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ee_a(ee_a), .ee_ce_n(ee_ce_n), .ee_oe_n(ee_oe_n), .ee_we_n(ee_we_n),
        .ee_d_o(ee_d_o), .ee_d_oe(ee_d_oe), .ee_d_i(ee_d_i)
    );

    always #5 clk = ~clk;

    // EEPROM model: captures on the we_n pulse, then reads bit 7 inverted while busy
    logic [7:0] mem [0:(1<<AW)-1];
    int         busy = 0;
    logic       stuck = 1'b0;
    localparam int BUSY_CLKS = 30;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem[13'h0123] <= 8'hA5;
            mem[13'h0001] <= 8'h5A;
            busy <= 0;
        end else if (!ee_ce_n && !ee_we_n) begin
            mem[ee_a] <= ee_d_o;
            busy <= BUSY_CLKS;
        end else if (busy > 0) begin
            busy <= busy - 1;
        end
    end

    always_comb begin
        ee_d_i = 8'h00;
        if (!ee_ce_n && !ee_oe_n) begin
            if (busy != 0 || stuck) ee_d_i = {~mem[ee_a][7], mem[ee_a][6:0]};
            else                    ee_d_i = mem[ee_a];
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 'h%0h expected 'h%0h", name, got, exp);
        end
    endtask

    logic prev_d_oe = 1'b0;
    logic prev_oe_low = 1'b0;

    task automatic bus_check();
        if (rst_n) begin
            checks++;
            if ((ee_d_oe && !ee_oe_n) || (!ee_we_n && !ee_oe_n) ||
                (prev_d_oe && !ee_oe_n) || (prev_oe_low && ee_d_oe)) begin
                errors++;
                $display("FAIL bus_rule at %0t d_oe=%0b oe_n=%0b we_n=%0b prev_d_oe=%0b prev_oe_low=%0b required no overlap",
                         $time, ee_d_oe, ee_oe_n, ee_we_n, prev_d_oe, prev_oe_low);
            end
        end
        prev_d_oe   = ee_d_oe;
        prev_oe_low = !ee_oe_n;
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata,
                          output int lat, output logic [7:0] rdata, output logic err,
                          output int oe_cnt, output int we_cnt, output int bursts,
                          output int ready_seen, output logic got);
        logic oe_prev;
        @(negedge clk);
        bus_check();
        check("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; oe_cnt = 0; we_cnt = 0; bursts = 0; ready_seen = 0; got = 1'b0;
        rdata = 8'h00; err = 1'b0; oe_prev = 1'b0;
        while (!got && lat < MAXW) begin
            @(negedge clk);
            lat++;
            bus_check();
            if (!ee_oe_n) oe_cnt++;
            if (!ee_oe_n && !oe_prev) bursts++;
            oe_prev = !ee_oe_n;
            if (!ee_we_n) we_cnt++;
            if (req_ready) ready_seen++;
            if (rsp_valid) begin
                got   = 1'b1;
                rdata = rsp_rdata;
                err   = rsp_err;
            end
        end
        check("rsp_within_budget", got, 1);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic [7:0]    exp_rdata;
        logic          exp_err;
        int            exp_lat;
        int            exp_oe;
        int            exp_we;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, oe_cnt, we_cnt, bursts, ready_seen, seen, n;
        logic [7:0] rdata;
        logic err, got;

`ifdef EEPROM_DATA_POLL_EN
        vecs[0] = '{1'b0, 13'h0123, 8'h00, 8'hA5, 1'b0, RDC+1, RDC, 0};
        vecs[1] = '{1'b1, 13'h1FFF, 8'h3C, 8'h3C, 1'b0, 0, -1, WEC};
        vecs[2] = '{1'b0, 13'h1FFF, 8'h00, 8'h3C, 1'b0, RDC+1, RDC, 0};
        vecs[3] = '{1'b1, 13'h0000, 8'h55, 8'h55, 1'b0, 0, -1, WEC};
        vecs[4] = '{1'b0, 13'h0000, 8'h00, 8'h55, 1'b0, RDC+1, RDC, 0};
        vecs[5] = '{1'b0, 13'h0001, 8'h00, 8'h5A, 1'b0, RDC+1, RDC, 0};
`else
        vecs[0] = '{1'b0, 13'h0123, 8'h00, 8'hA5, 1'b0, RDC+1, RDC, 0};
        vecs[1] = '{1'b1, 13'h1FFF, 8'h3C, 8'hA5, 1'b0, 1+WEC+1+WC+1, 0, WEC};
        vecs[2] = '{1'b0, 13'h1FFF, 8'h00, 8'h3C, 1'b0, RDC+1, RDC, 0};
        vecs[3] = '{1'b1, 13'h0000, 8'h55, 8'h3C, 1'b0, 1+WEC+1+WC+1, 0, WEC};
        vecs[4] = '{1'b0, 13'h0000, 8'h00, 8'h55, 1'b0, RDC+1, RDC, 0};
        vecs[5] = '{1'b0, 13'h0001, 8'h00, 8'h5A, 1'b0, RDC+1, RDC, 0};
`endif

        #1;
        check("rst_ce_n", ee_ce_n, 1);
        check("rst_oe_n", ee_oe_n, 1);
        check("rst_we_n", ee_we_n, 1);
        check("rst_d_oe", ee_d_oe, 0);
        check("rst_a", ee_a, 0);
        check("rst_d_o", ee_d_o, 0);
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rdata, err, oe_cnt, we_cnt, bursts, ready_seen, got);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("v%0d_ready_low", i), ready_seen, 0);
            check($sformatf("v%0d_we_low_clks", i), we_cnt, vecs[i].exp_we);
            if (vecs[i].exp_lat != 0) check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].exp_oe >= 0) check($sformatf("v%0d_oe_low_clks", i), oe_cnt, vecs[i].exp_oe);
        end

`ifdef EEPROM_DATA_POLL_EN
        // Busy for BUSY_CLKS after the pulse: several polls, finishing soon after busy ends
        do_req(1'b1, 13'h0000, 8'h80, lat, rdata, err, oe_cnt, we_cnt, bursts, ready_seen, got);
        check("poll_rdata", rdata, 8'h80);
        check("poll_err", err, 0);
        check("poll_multi_burst", bursts > 1, 1);
        check("poll_latency_bound", lat <= 1 + WEC + BUSY_CLKS + RDC + 2, 1);
        check("poll_ready_low", ready_seen, 0);

        stuck = 1'b1;
        do_req(1'b1, 13'h0002, 8'h11, lat, rdata, err, oe_cnt, we_cnt, bursts, ready_seen, got);
        check("poll_timeout_err", err, 1);
        check("poll_timeout_lat_min", lat >= 1 + WEC + 1 + WC, 1);
        check("poll_timeout_lat_max", lat <= 1 + WEC + 1 + WC + RDC + 2, 1);
        stuck = 1'b0;
`endif

        // Reset in the middle of the write pulse
        @(negedge clk);
        bus_check();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 13'h0100; req_wdata = 8'hC3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (ee_we_n && n < 20) begin
            @(negedge clk);
            bus_check();
            n++;
        end
        check("rst_mid_pulse_reached", ee_we_n, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_we_n", ee_we_n, 1);
        check("rst_mid_ce_n", ee_ce_n, 1);
        check("rst_mid_d_oe", ee_d_oe, 0);
        check("rst_mid_ready", req_ready, 1);
        seen = 0;
        prev_d_oe = 1'b0;
        prev_oe_low = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rst_n = 1'b1;
        repeat (WC + 10) begin
            @(negedge clk);
            bus_check();
            if (rsp_valid) seen++;
        end
        check("rst_no_rsp", seen, 0);
        do_req(1'b0, 13'h0123, 8'h00, lat, rdata, err, oe_cnt, we_cnt, bursts, ready_seen, got);
        check("post_rst_rdata", rdata, 8'hA5);
        check("post_rst_latency", lat, RDC + 1);
        check("post_rst_oe_clks", oe_cnt, RDC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
